// File: rtl/pc_seq_pkg.sv
// Shared opcode encodings, flag bit positions and sequencer state enum.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_END  = 4'b0001;
  localparam logic [OP_W-1:0] OP_CALL = 4'b1010;
  localparam logic [OP_W-1:0] OP_RET  = 4'b1011;
  localparam logic [OP_W-1:0] OP_BRIN = 4'b1100;
  localparam logic [OP_W-1:0] OP_BETO = 4'b1101;
  localparam logic [OP_W-1:0] OP_BMNQ = 4'b1110;

  // Flag register bit positions
  localparam int unsigned FLAG_EQ = 0;
  localparam int unsigned FLAG_LT = 1;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO: occupancy counter is reset, storage is not.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     depth
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;

  // Low bits of the occupancy address the next free slot; one below is the top
  assign wr_ptr  = depth[PTR_W-1:0];
  assign top_ptr = depth[PTR_W-1:0] - PTR_W'(1);
  assign top_c   = mem[top_ptr];
  assign full_c  = (depth == DEPTH_W'(DEPTH));
  assign empty_c = (depth == '0);

  // Occupancy counter; push/pop are guarded against full/empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (push && !full_c) begin
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty_c) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

  // Entry storage, written on accepted push only
  always_ff @(posedge clk) begin
    if (push && !full_c && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with flag-conditioned branches and a return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         IMM_W     = 18,
  parameter int unsigned         FLAG_W    = 2,
  parameter int unsigned         RAS_DEPTH = 4,
  parameter int unsigned         PC_STEP   = 4,
  parameter logic [ADDR_W-1:0]   RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         flags_we,
  input  logic [FLAG_W-1:0]            alu_flags,
  input  logic [3:0]                   op,
  input  logic [IMM_W-1:0]             imm,
  output logic [ADDR_W-1:0]            pc,
  output logic                         running,
  output logic                         end_flag,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  state_e              state, state_next;
  logic [ADDR_W-1:0]   pc_next, pc_inc, imm_ext, top_c;
  logic [FLAG_W-1:0]   flags, flags_next;
  logic                ovf_next, unf_next;
  logic                push_c, pop_c, clear_c, full_c, empty_c;

  assign pc_inc  = pc + ADDR_W'(PC_STEP);
  assign imm_ext = ADDR_W'(imm);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_c),
    .push    (push_c),
    .pop     (pop_c),
    .din     (pc_inc),
    .top_c   (top_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .depth   (ras_depth)
  );

  // State register with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      end_flag <= 1'b0;
    end else begin
      state    <= state_next;
      running  <= (state_next == ST_RUN);
      end_flag <= (state_next == ST_HALT);
    end
  end

  // PC, flag register and sticky stack error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VEC;
      flags   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc      <= pc_next;
      flags   <= flags_next;
      ras_ovf <= ovf_next;
      ras_unf <= unf_next;
    end
  end

  // Next-state, next-PC and stack control
  always_comb begin
    state_next = state;
    pc_next    = pc;
    flags_next = flags;
    ovf_next   = ras_ovf;
    unf_next   = ras_unf;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    clear_c    = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_RUN;
          pc_next    = RESET_VEC;
          flags_next = '0;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          clear_c    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          // New flags land after this instruction's branch decision
          if (flags_we) flags_next = alu_flags;
          case (op)
            OP_NOP:  pc_next = pc_inc;
            OP_END:  state_next = ST_HALT;
            OP_CALL: begin
              pc_next = imm_ext;
              if (full_c) ovf_next = 1'b1;
              else        push_c   = 1'b1;
            end
            OP_RET: begin
              if (empty_c) begin
                pc_next  = pc_inc;
                unf_next = 1'b1;
              end else begin
                pc_next = top_c;
                pop_c   = 1'b1;
              end
            end
            OP_BRIN: pc_next = imm_ext;
            OP_BETO: pc_next = flags[FLAG_EQ] ? imm_ext : pc_inc;
            OP_BMNQ: pc_next = flags[FLAG_LT] ? imm_ext : pc_inc;
            default: pc_next = pc_inc;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  localparam logic [3:0] NOP  = 4'b0000;
  localparam logic [3:0] ENDO = 4'b0001;
  localparam logic [3:0] CALL = 4'b1010;
  localparam logic [3:0] RET  = 4'b1011;
  localparam logic [3:0] BRIN = 4'b1100;
  localparam logic [3:0] BETO = 4'b1101;
  localparam logic [3:0] BMNQ = 4'b1110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        flags_we;
  logic [1:0]  alu_flags;
  logic [3:0]  op;
  logic [17:0] imm;
  logic [31:0] pc;
  logic        running;
  logic        end_flag;
  logic [2:0]  ras_depth;
  logic        ras_ovf;
  logic        ras_unf;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .flags_we  (flags_we),
    .alu_flags (alu_flags),
    .op        (op),
    .imm       (imm),
    .pc        (pc),
    .running   (running),
    .end_flag  (end_flag),
    .ras_depth (ras_depth),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stall = 1'b0; flags_we = 1'b0;
    alu_flags = 2'b00; op = NOP; imm = '0;
    step(); step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if ({running, end_flag, ras_depth, ras_ovf, ras_unf} !== 7'b0) begin failures++;
      $display("FAIL reset_status got=%b exp=%b", {running, end_flag, ras_depth, ras_ovf, ras_unf}, 7'b0); end
    reset = 1'b1;
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b exp=0", running); end
  endtask

  task automatic test_nops();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    start = 1'b1; op = NOP;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++; if (pc !== exp_pc[i]) begin failures++; $display("FAIL nop_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
    end
    // start in RUN is ignored
    start = 1'b1; step(); start = 1'b0;
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL start_in_run got=%h exp=%h", pc, 32'h10); end
  endtask

  task automatic test_flags_branch();
    // pc = 0x10: capture EQ flag, then BETO taken
    op = NOP; flags_we = 1'b1; alu_flags = 2'b01; step(); flags_we = 1'b0;
    op = BETO; imm = 18'h40; step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL beto_taken got=%h exp=%h", pc, 32'h40); end
    // clear flags, then BETO with same-cycle flags_we must use old (00) value
    op = NOP; flags_we = 1'b1; alu_flags = 2'b00; step();
    op = BETO; alu_flags = 2'b01; step(); flags_we = 1'b0;
    checks++; if (pc !== 32'h48) begin failures++; $display("FAIL beto_same_cycle got=%h exp=%h", pc, 32'h48); end
    // the flag written alongside that BETO now takes effect
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL beto_next got=%h exp=%h", pc, 32'h40); end
    op = BMNQ; imm = 18'h80; step();
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL bmnq_not_taken got=%h exp=%h", pc, 32'h44); end
    op = NOP; flags_we = 1'b1; alu_flags = 2'b10; step(); flags_we = 1'b0;
    op = BMNQ; step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL bmnq_taken got=%h exp=%h", pc, 32'h80); end
    op = 4'b0111; step();
    checks++; if (pc !== 32'h84) begin failures++; $display("FAIL other_op got=%h exp=%h", pc, 32'h84); end
  endtask

  task automatic test_call_ret();
    op = BRIN; imm = 18'h10; step();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL brin got=%h exp=%h", pc, 32'h10); end
    op = CALL; imm = 18'h100; step();
    checks++; if (pc !== 32'h100 || ras_depth !== 3'd1) begin failures++;
      $display("FAIL call got pc=%h depth=%0d exp pc=%h depth=1", pc, ras_depth, 32'h100); end
    op = NOP; step();
    checks++; if (pc !== 32'h104 || ras_depth !== 3'd1) begin failures++;
      $display("FAIL call_nop got pc=%h depth=%0d exp pc=%h depth=1", pc, ras_depth, 32'h104); end
    op = RET; step();
    checks++; if (pc !== 32'h14 || ras_depth !== 3'd0) begin failures++;
      $display("FAIL ret got pc=%h depth=%0d exp pc=%h depth=0", pc, ras_depth, 32'h14); end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] call_tgt [5];
    logic [31:0] ret_pc   [5];
    call_tgt[0] = 32'h200; call_tgt[1] = 32'h300; call_tgt[2] = 32'h400;
    call_tgt[3] = 32'h500; call_tgt[4] = 32'h600;
    // pushed: 0x18, 0x204, 0x304, 0x404; the fifth (0x504) is dropped
    ret_pc[0] = 32'h404; ret_pc[1] = 32'h304; ret_pc[2] = 32'h204;
    ret_pc[3] = 32'h18;  ret_pc[4] = 32'h1C;
    op = CALL;
    for (int i = 0; i < 5; i++) begin
      imm = 18'(call_tgt[i]); step();
      checks++; if (pc !== call_tgt[i]) begin failures++; $display("FAIL call%0d_pc got=%h exp=%h", i, pc, call_tgt[i]); end
      if (i == 3) begin
        checks++; if (ras_depth !== 3'd4 || ras_ovf !== 1'b0) begin failures++;
          $display("FAIL full_no_ovf got depth=%0d ovf=%b exp depth=4 ovf=0", ras_depth, ras_ovf); end
      end
    end
    checks++; if (ras_depth !== 3'd4 || ras_ovf !== 1'b1) begin failures++;
      $display("FAIL ovf got depth=%0d ovf=%b exp depth=4 ovf=1", ras_depth, ras_ovf); end
    op = RET;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (pc !== ret_pc[i]) begin failures++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc, ret_pc[i]); end
      if (i == 3) begin
        checks++; if (ras_depth !== 3'd0 || ras_unf !== 1'b0) begin failures++;
          $display("FAIL empty_no_unf got depth=%0d unf=%b exp depth=0 unf=0", ras_depth, ras_unf); end
      end
    end
    checks++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b1 || ras_depth !== 3'd0) begin failures++;
      $display("FAIL unf got unf=%b ovf=%b depth=%0d exp unf=1 ovf=1 depth=0", ras_unf, ras_ovf, ras_depth); end
  endtask

  task automatic test_stall_end_restart();
    // pc = 0x1C
    op = BRIN; imm = 18'h80; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h1C) begin failures++; $display("FAIL stall%0d_pc got=%h exp=%h", i, pc, 32'h1C); end
    end
    stall = 1'b0; step();
    checks++; if (pc !== 32'h80) begin failures++; $display("FAIL stall_release got=%h exp=%h", pc, 32'h80); end
    op = ENDO; stall = 1'b1; step(); stall = 1'b0;
    checks++; if (running !== 1'b1 || end_flag !== 1'b0) begin failures++;
      $display("FAIL end_stalled got run=%b end=%b exp run=1 end=0", running, end_flag); end
    step();
    checks++; if (end_flag !== 1'b1 || running !== 1'b0 || pc !== 32'h80) begin failures++;
      $display("FAIL end got end=%b run=%b pc=%h exp end=1 run=0 pc=%h", end_flag, running, pc, 32'h80); end
    op = BRIN; imm = 18'h300; step(); step();
    checks++; if (pc !== 32'h80 || end_flag !== 1'b1) begin failures++;
      $display("FAIL halt_hold got pc=%h end=%b exp pc=%h end=1", pc, end_flag, 32'h80); end
    op = NOP; start = 1'b1; step(); start = 1'b0;
    checks++; if (pc !== 32'h0 || running !== 1'b1 || end_flag !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      failures++; $display("FAIL restart got pc=%h run=%b end=%b ovf=%b unf=%b exp pc=0 run=1 end=0 ovf=0 unf=0",
                           pc, running, end_flag, ras_ovf, ras_unf); end
    // flags must have been cleared by start: BETO not taken
    op = BETO; imm = 18'h40; step();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL restart_flags got=%h exp=%h", pc, 32'h4); end
  endtask

  task automatic test_async_reset();
    op = CALL; imm = 18'h100; step();
    imm = 18'h200; step();
    checks++; if (ras_depth !== 3'd2 || pc !== 32'h200) begin failures++;
      $display("FAIL pre_reset got depth=%0d pc=%h exp depth=2 pc=%h", ras_depth, pc, 32'h200); end
    #2 reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || {running, end_flag, ras_depth, ras_ovf, ras_unf} !== 7'b0) begin failures++;
      $display("FAIL async_reset got pc=%h status=%b exp pc=0 status=0000000",
               pc, {running, end_flag, ras_depth, ras_ovf, ras_unf}); end
    step();
    reset = 1'b1; op = NOP;
    step();
    checks++; if (pc !== 32'h0 || running !== 1'b0) begin failures++;
      $display("FAIL post_reset_idle got pc=%h run=%b exp pc=0 run=0", pc, running); end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_flags_branch();
    test_call_ret();
    test_overflow_underflow();
    test_stall_end_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of PC and return addresses.
REQ-002 SHALL have parameter IMM_W, default 18, width of branch target immediate (IMM_W <= ADDR_W).
REQ-003 SHALL have parameter FLAG_W, default 2, width of the ALU flag register; bit0 = equal, bit1 = less-than.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >= 2).
REQ-005 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-006 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset and on start.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  begin execution from RESET_VEC.
REQ-010 SHALL have port stall  input  1  hold PC, stack and flags this cycle.
REQ-011 SHALL have port flags_we  input  1  capture alu_flags into flag register.
REQ-012 SHALL have port alu_flags  input  FLAG_W  ALU condition flags.
REQ-013 SHALL have port op  input  4  control opcode of current instruction.
REQ-014 SHALL have port imm  input  IMM_W  branch/call target, zero-extended to ADDR_W.
REQ-015 SHALL have port pc  output  ADDR_W  registered current PC.
REQ-016 SHALL have port running  output  1  high in state RUN.
REQ-017 SHALL have port end_flag  output  1  high in state HALT.
REQ-018 SHALL have port ras_depth  output  $clog2(RAS_DEPTH)+1  current stack occupancy.
REQ-019 SHALL have port ras_ovf  output  1  sticky stack-overflow error.
REQ-020 SHALL have port ras_unf  output  1  sticky stack-underflow error.

Function
REQ-021 SHALL implement states IDLE, RUN, HALT; IDLE --start--> RUN; RUN --op END, not stalled--> HALT; HALT --start--> RUN; start in RUN is ignored.
REQ-022 SHALL, on start accepted (IDLE or HALT), load pc = RESET_VEC, empty stack, clear flag register, ras_ovf and ras_unf, next cycle running = 1.
REQ-023 SHALL hold pc, stack, flags in IDLE and HALT regardless of op.
REQ-024 SHALL, in RUN with stall = 1, hold pc, stack, flag register and state unchanged.
REQ-025 SHALL, in RUN not stalled, compute next pc by op: 0000 NOP -> pc+PC_STEP; 0001 END -> pc held; 1010 CALL -> imm; 1011 RET -> top of stack; 1100 BRIN -> imm; 1101 BETO -> imm if flag[0] else pc+PC_STEP; 1110 BMNQ -> imm if flag[1] else pc+PC_STEP; other -> pc+PC_STEP.
REQ-026 SHALL evaluate conditional branches against the registered flag value; flags_we in the same cycle affects only the following instruction.
REQ-027 SHALL capture alu_flags when flags_we = 1, state RUN, stall = 0.
REQ-028 SHALL, on CALL, push pc+PC_STEP and increment ras_depth; when ras_depth = RAS_DEPTH, push is dropped, ras_ovf set, jump to imm still taken.
REQ-029 SHALL, on RET, pop and decrement ras_depth; when ras_depth = 0, pc = pc+PC_STEP and ras_unf set.
REQ-030 SHALL perform PC arithmetic modulo 2^ADDR_W (wrap, no error).
REQ-031 SHALL have single-cycle latency: pc updates on the clock edge after the op is presented.

Reset
REQ-032 SHALL, while reset = 0, force state IDLE, pc = RESET_VEC, flags = 0, ras_depth = 0, ras_ovf = ras_unf = 0, running = end_flag = 0, asynchronously, including mid-execution.
REQ-033 SHALL leave stack entry contents undefined after reset (no reset required on storage).

Structure
REQ-034 SHALL take opcode constants and the state enum from shared package pc_seq_pkg.
REQ-035 SHALL instantiate one sub-module ras_stack (parametrised LIFO with push, pop, full, empty, depth).

Verification
REQ-036 SHALL check: reset release, start pulse, 3 NOPs -> pc = 0, 4, 8, 12; running = 1.
REQ-037 SHALL check: flags_we with alu_flags = 2'b01 then BETO imm = 0x40 -> pc = 0x40; same BETO with flags_we in same cycle from 2'b00 -> pc+4.
REQ-038 SHALL check: CALL 0x100 at pc 0x10, NOP, RET -> pc = 0x100, 0x104, 0x14; ras_depth 1 then 0.
REQ-039 SHALL check: 5 CALLs with RAS_DEPTH = 4 -> ras_ovf = 1, ras_depth = 4; 5 RETs -> fifth RET gives pc+4 and ras_unf = 1.
REQ-040 SHALL check: stall held 3 cycles during BRIN -> pc unchanged until stall drops; END -> end_flag = 1, pc frozen; start -> pc = RESET_VEC, errors cleared.
REQ-041 SHALL check: reset asserted mid-RUN with ras_depth = 2 -> all outputs at reset values before next clock edge.
